// File: rtl/xbar_rr_switch.sv
// Registered N_IN x N_OUT crossbar with a round-robin arbiter and a one-entry output register per output.
// Words addressed to a destination beyond N_OUT-1 are accepted, discarded and counted in a saturating counter.
module xbar_rr_switch #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int CNT_W = 8,
  localparam int DEST_W = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*DW-1:0]      in_data,
  input  logic [N_IN*DEST_W-1:0]  in_dest,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*DW-1:0]     out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(N_IN);
  localparam int NW    = $clog2(N_IN + 1);
  localparam int SUM_W = CNT_W + NW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_OUT-1:0]                 out_valid_q, out_valid_d;
  logic [N_OUT-1:0][DW-1:0]         out_data_q, out_data_d;
  logic [N_OUT-1:0][PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]                 drop_cnt_q, drop_cnt_d;

  logic [N_OUT-1:0][N_IN-1:0]       gnt_s;
  logic [N_OUT-1:0][PTR_W-1:0]      win_s;
  logic [N_IN-1:0]                  drop_s;
  logic [N_IN-1:0]                  in_ready_s;
  logic [NW-1:0]                    drop_n_s;
  logic [SUM_W-1:0]                 drop_sum_s;

  // Out-of-range destinations only exist when N_OUT is not a power of two.
  if ((1 << DEST_W) > N_OUT) begin : g_drop
    always_comb begin
      drop_s = '0;
      for (int i = 0; i < N_IN; i++) begin
        drop_s[i] = in_valid[i] && (in_dest[i*DEST_W +: DEST_W] >= DEST_W'(N_OUT));
      end
    end
  end else begin : g_no_drop
    assign drop_s = '0;
  end

  // Per-output round-robin search starting at ptr, gated by slot availability.
  always_comb begin : p_arb
    logic             found_v;
    logic [PTR_W:0]   idx_v;
    gnt_s   = '0;
    win_s   = '0;
    found_v = 1'b0;
    idx_v   = '0;
    for (int j = 0; j < N_OUT; j++) begin
      found_v = 1'b0;
      for (int off = 0; off < N_IN; off++) begin
        idx_v = {1'b0, ptr_q[j]} + (PTR_W+1)'(off);
        if (idx_v >= (PTR_W+1)'(N_IN)) begin
          idx_v = idx_v - (PTR_W+1)'(N_IN);
        end else begin
          idx_v = idx_v;
        end
        if (!found_v && in_valid[idx_v[PTR_W-1:0]] &&
            (in_dest[idx_v[PTR_W-1:0]*DEST_W +: DEST_W] == DEST_W'(j))) begin
          found_v  = 1'b1;
          win_s[j] = idx_v[PTR_W-1:0];
        end else begin
          found_v  = found_v;
        end
      end
      if (found_v && (!out_valid_q[j] || out_ready[j])) begin
        gnt_s[j][win_s[j]] = 1'b1;
      end else begin
        gnt_s[j] = '0;
      end
    end
  end

  // An input is ready when its destination grants it or it is being dropped.
  always_comb begin
    in_ready_s = drop_s;
    for (int j = 0; j < N_OUT; j++) begin
      in_ready_s = in_ready_s | gnt_s[j];
    end
  end

  // Output slot and pointer next state: load on grant, else drain on ready, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    for (int j = 0; j < N_OUT; j++) begin
      if (|gnt_s[j]) begin
        out_valid_d[j] = 1'b1;
        out_data_d[j]  = in_data[win_s[j]*DW +: DW];
        ptr_d[j]       = (win_s[j] == PTR_W'(N_IN - 1)) ? '0 : win_s[j] + PTR_W'(1);
      end else if (out_ready[j]) begin
        out_valid_d[j] = 1'b0;
      end else begin
        out_valid_d[j] = out_valid_q[j];
      end
    end
  end

  // Saturating accumulation of dropped words; several inputs may drop in one cycle.
  always_comb begin
    drop_n_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      drop_n_s = drop_n_s + NW'(drop_s[i]);
    end
    drop_sum_s = SUM_W'(drop_cnt_q) + SUM_W'(drop_n_s);
    if (drop_sum_s > SUM_W'(CNT_MAX)) begin
      drop_cnt_d = CNT_MAX;
    end else begin
      drop_cnt_d = drop_sum_s[CNT_W-1:0];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      ptr_q       <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_xbar_rr_switch.sv
// Directed bench for xbar_rr_switch: a default 4x4 instance plus a 4x3 instance with a 2-bit drop counter.
module tb_xbar_rr_switch;

  logic        clk;
  logic        rst;

  logic [31:0] a_in_data;
  logic [7:0]  a_in_dest;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_out_ready;
  logic [7:0]  a_drop_cnt;

  logic [31:0] b_in_data;
  logic [7:0]  b_in_dest;
  logic [3:0]  b_in_valid;
  logic [3:0]  b_in_ready;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [1:0]  b_drop_cnt;

  int checks;
  int failures;

  xbar_rr_switch #(.N_IN(4), .N_OUT(4), .DW(8), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_dest(a_in_dest), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .drop_cnt(a_drop_cnt)
  );

  xbar_rr_switch #(.N_IN(4), .N_OUT(3), .DW(8), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_dest(b_in_dest), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .drop_cnt(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] d, input logic [1:0] dest);
    a_in_data[i*8 +: 8] = d;
    a_in_dest[i*2 +: 2] = dest;
  endtask

  task automatic do_reset();
    a_in_valid = 4'b0000;
    b_in_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_data = 32'h0; a_in_dest = 8'h0; a_in_valid = 4'b0; a_out_ready = 4'hF;
    b_in_data = 32'h0; b_in_dest = 8'h0; b_in_valid = 4'b0; b_out_ready = 3'b111;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 4'b0000) begin failures++; $display("FAIL reset_out_valid got=%b exp=0000", a_out_valid); end
    checks++;
    if (a_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", a_out_data); end
    checks++;
    if (a_drop_cnt !== 8'h0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", a_drop_cnt); end
    checks++;
    if (a_in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", a_in_ready); end
    tick();
  endtask

  task automatic test_single_path();
    set_lane(2, 8'hA5, 2'd1);
    a_in_valid = 4'b0100;
    a_out_ready = 4'hF;
    #1;
    checks++;
    if (a_in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready got=%b exp=0100", a_in_ready); end
    tick();
    a_in_valid = 4'b0000;
    checks++;
    if (a_out_valid !== 4'b0010) begin failures++; $display("FAIL single_out_valid got=%b exp=0010", a_out_valid); end
    checks++;
    if (a_out_data[15:8] !== 8'hA5) begin failures++; $display("FAIL single_out_data got=%h exp=a5", a_out_data[15:8]); end
    tick();
    checks++;
    if (a_out_valid !== 4'b0000) begin failures++; $display("FAIL single_drain got=%b exp=0000", a_out_valid); end
  endtask

  task automatic test_permutation();
    set_lane(0, 8'h10, 2'd3);
    set_lane(1, 8'h11, 2'd2);
    set_lane(2, 8'h12, 2'd1);
    set_lane(3, 8'h13, 2'd0);
    a_in_valid = 4'b1111;
    #1;
    checks++;
    if (a_in_ready !== 4'b1111) begin failures++; $display("FAIL perm_in_ready got=%b exp=1111", a_in_ready); end
    tick();
    a_in_valid = 4'b0000;
    checks++;
    if (a_out_valid !== 4'b1111) begin failures++; $display("FAIL perm_out_valid got=%b exp=1111", a_out_valid); end
    checks++;
    if (a_out_data !== 32'h10111213) begin failures++; $display("FAIL perm_out_data got=%h exp=10111213", a_out_data); end
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] er;
    logic [7:0] ed;
    do_reset();
    set_lane(0, 8'hA0, 2'd0);
    set_lane(1, 8'hA1, 2'd0);
    set_lane(3, 8'hA3, 2'd0);
    a_in_valid = 4'b1011;
    a_out_ready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      case (c % 3)
        0:       begin er = 4'b0001; ed = 8'hA0; end
        1:       begin er = 4'b0010; ed = 8'hA1; end
        default: begin er = 4'b1000; ed = 8'hA3; end
      endcase
      #1;
      checks++;
      if (a_in_ready !== er) begin failures++; $display("FAIL fair_grant_%0d got=%b exp=%b", c, a_in_ready, er); end
      tick();
      checks++;
      if (a_out_valid[0] !== 1'b1 || a_out_data[7:0] !== ed) begin
        failures++; $display("FAIL fair_out_%0d got=%b/%h exp=1/%h", c, a_out_valid[0], a_out_data[7:0], ed);
      end
    end
    a_in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    set_lane(0, 8'h55, 2'd2);
    a_in_valid = 4'b0001;
    a_out_ready = 4'b1011;
    tick();
    checks++;
    if (a_out_valid[2] !== 1'b1 || a_out_data[23:16] !== 8'h55) begin
      failures++; $display("FAIL bp_load got=%b/%h exp=1/55", a_out_valid[2], a_out_data[23:16]);
    end
    set_lane(1, 8'h66, 2'd2);
    a_in_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (a_in_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_stall_ready_%0d got=%b exp=0", c, a_in_ready[1]); end
      tick();
      checks++;
      if (a_out_valid[2] !== 1'b1 || a_out_data[23:16] !== 8'h55) begin
        failures++; $display("FAIL bp_hold_%0d got=%b/%h exp=1/55", c, a_out_valid[2], a_out_data[23:16]);
      end
    end
    a_out_ready = 4'hF;
    #1;
    checks++;
    if (a_in_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", a_in_ready); end
    tick();
    a_in_valid = 4'b0000;
    checks++;
    if (a_out_valid[2] !== 1'b1 || a_out_data[23:16] !== 8'h66) begin
      failures++; $display("FAIL bp_new_word got=%b/%h exp=1/66", a_out_valid[2], a_out_data[23:16]);
    end
    tick();
    checks++;
    if (a_out_valid[2] !== 1'b0 || a_out_data[23:16] !== 8'h66) begin
      failures++; $display("FAIL bp_drain_hold got=%b/%h exp=0/66", a_out_valid[2], a_out_data[23:16]);
    end
  endtask

  task automatic test_drop_saturation();
    logic [1:0] ec;
    do_reset();
    b_out_ready = 3'b111;
    b_in_data[7:0] = 8'h77;
    b_in_dest[1:0] = 2'd3;
    b_in_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      ec = (c < 2) ? 2'(c + 1) : 2'd3;
      #1;
      checks++;
      if (b_in_ready[0] !== 1'b1) begin failures++; $display("FAIL drop_ready_%0d got=%b exp=1", c, b_in_ready[0]); end
      tick();
      checks++;
      if (b_drop_cnt !== ec || b_out_valid !== 3'b000) begin
        failures++; $display("FAIL drop_cnt_%0d got=%0d/%b exp=%0d/000", c, b_drop_cnt, b_out_valid, ec);
      end
    end
    do_reset();
    b_in_data[15:8] = 8'h78;
    b_in_dest[3:2] = 2'd3;
    b_in_dest[5:4] = 2'd1;
    b_in_valid = 4'b0111;
    #1;
    checks++;
    if (b_in_ready !== 4'b0111) begin failures++; $display("FAIL drop_multi_ready got=%b exp=0111", b_in_ready); end
    tick();
    b_in_valid = 4'b0000;
    checks++;
    if (b_drop_cnt !== 2'd2 || b_out_valid !== 3'b010) begin
      failures++; $display("FAIL drop_multi_cnt got=%0d/%b exp=2/010", b_drop_cnt, b_out_valid);
    end
  endtask

  task automatic test_async_reset();
    a_out_ready = 4'hF;
    set_lane(1, 8'h21, 2'd2);
    a_in_valid = 4'b0010;
    tick();
    set_lane(0, 8'h30, 2'd0);
    set_lane(1, 8'h31, 2'd1);
    set_lane(3, 8'h33, 2'd3);
    a_in_valid = 4'b1011;
    a_out_ready = 4'b0100;
    tick();
    a_in_valid = 4'b0000;
    a_out_ready = 4'b0000;
    checks++;
    if (a_out_valid !== 4'b1011) begin failures++; $display("FAIL ar_setup got=%b exp=1011", a_out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 4'b0000 || a_out_data !== 32'h0) begin
      failures++; $display("FAIL ar_clear got=%b/%h exp=0000/00000000", a_out_valid, a_out_data);
    end
    checks++;
    if (a_drop_cnt !== 8'h0 || b_drop_cnt !== 2'd0) begin
      failures++; $display("FAIL ar_drop_cnt got=%0d/%0d exp=0/0", a_drop_cnt, b_drop_cnt);
    end
    rst = 1'b0;
    set_lane(0, 8'h40, 2'd2);
    set_lane(1, 8'h41, 2'd2);
    set_lane(3, 8'h43, 2'd2);
    a_in_valid = 4'b1011;
    a_out_ready = 4'hF;
    #1;
    checks++;
    if (a_in_ready !== 4'b0001) begin failures++; $display("FAIL ar_first_grant got=%b exp=0001", a_in_ready); end
    tick();
    a_in_valid = 4'b0000;
    checks++;
    if (a_out_valid !== 4'b0100 || a_out_data[23:16] !== 8'h40) begin
      failures++; $display("FAIL ar_first_word got=%b/%h exp=0100/40", a_out_valid, a_out_data[23:16]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_path();
    test_permutation();
    test_fairness();
    test_backpressure();
    test_drop_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_rr_switch.md
Name: xbar_rr_switch

Overview:
- Parametrised, registered N_IN x N_OUT crossbar switch; successor to the team's fixed 4x4 combinational crossbar.
- Each input carries a data word and a destination index. Each output has a round-robin arbiter and a one-entry output register, with valid/ready flow control on both sides.
- Sits between producer lanes and consumer lanes in the datapath interconnect.
- Adds what the fixed crossbar lacks: contention handling, backpressure, fairness and invalid-destination accounting.

Parameters:
- N_IN, 4, number of input ports (>=2)
- N_OUT, 4, number of output ports (>=2)
- DW, 8, data width per port in bits
- DEST_W, $clog2(N_OUT), destination index width (localparam, minimum 1)
- CNT_W, 8, width of the drop counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  N_IN*DW  input i occupies bits [i*DW +: DW]
- in_dest  input  N_IN*DEST_W  destination output index for input i, at [i*DEST_W +: DEST_W]
- in_valid  input  N_IN  input i presents a word
- in_ready  output  N_IN  input i word accepted this cycle
- out_data  output  N_OUT*DW  output j register, at [j*DW +: DW]
- out_valid  output  N_OUT  output j register holds a word
- out_ready  input  N_OUT  consumer j takes the word this cycle
- drop_cnt  output  CNT_W  saturating count of words dropped for out-of-range destination

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, all arbiter pointers ptr[j]=0, drop_cnt=0. Any word in flight is discarded. in_ready is combinational and reads 0 while no inputs are valid.
- Request: input i requests output j when in_valid[i]=1 and in_dest[i]==j (with j<N_OUT).
- Output slot j can accept when out_valid[j]=0 or out_ready[j]=1. This allows full throughput of one word per output per cycle.
- Arbitration: per output j, round-robin.
  - Search starts at input ptr[j] and wraps modulo N_IN; the first requesting input k wins.
  - The grant is issued only if slot j can accept.
- Pointer update: on a grant to k, ptr[j] <= (k+1) mod N_IN on the clock edge. With no grant, ptr[j] is unchanged.
- in_ready[i] = granted by its destination output, OR the input is being dropped (see below). It is a combinational function of in_valid, in_dest, out_valid, out_ready and ptr.
- Producers must hold in_data and in_dest stable while in_valid=1 and in_ready=0. Producers must not make in_valid depend on in_ready.
- Transfer: on a grant, out_data[j] <= in_data[k] and out_valid[j] <= 1 at the next edge. Latency is one cycle from acceptance to out_valid.
- Drain: out_ready[j]=1 with out_valid[j]=1 and no new grant gives out_valid[j] <= 0. out_data holds its last value.
- Drain and grant in the same cycle: the register is overwritten with the new word and out_valid stays 1.
- Stall: out_valid[j]=1 with out_ready[j]=0 gives no grant for j. The register is held, and requesting inputs see in_ready=0.
- Independent outputs: inputs with distinct destinations are all served in the same cycle.
- One grant per output per cycle. An input is granted by at most one output because it has a single destination.
- Out-of-range destination (in_dest[i] >= N_OUT, possible only when N_OUT is not a power of two):
  - in_ready[i]=1 immediately and the word is discarded.
  - drop_cnt increments by the number of such inputs that cycle.
  - drop_cnt saturates at 2^CNT_W-1 and never wraps.
- out_ready to an empty slot has no effect.
- out_valid, out_data, ptr and drop_cnt are registers only. No combinational path exists from inputs to out_valid or out_data.

Test Plan:
- Single path: N_IN=N_OUT=4. Input 2 presents 8'hA5, dest 1; out_ready=all 1 → in_ready=4'b0100 in that cycle; next cycle out_valid=4'b0010, out_data[15:8]=8'hA5.
- Permutation: inputs 0..3 present 8'h10,8'h11,8'h12,8'h13 with dests 3,2,1,0 in one cycle → in_ready=4'b1111; next cycle outputs 0..3 hold 8'h13,8'h12,8'h11,8'h10.
- Contention fairness: inputs 0,1,3 all valid continuously to dest 0, out_ready[0]=1, starting from reset → grants to inputs 0,1,3,0,1,3 on consecutive cycles; ptr[0] sequence 1,2,0,1,2,0.
- Backpressure: output 2 holds 8'h55 with out_ready[2]=0 for 3 cycles while input 1 requests dest 2 with 8'h66 → in_ready[1]=0 and out_data[2] stays 8'h55. On the cycle out_ready[2]=1, in_ready[1]=1; next cycle out_data[2]=8'h66 and out_valid[2]=1 (no bubble).
- Drop and saturation: N_OUT=3, CNT_W=2. Input 0 presents dest 3 for 5 cycles → in_ready[0]=1 each cycle, no out_valid asserted, drop_cnt 1,2,3,3,3.
- Async reset mid-operation: assert rst between clock edges while out_valid=4'b1011 → out_valid=0, out_data=0 and drop_cnt=0 immediately, before the next edge. After release, the first grant starts from input 0.
